// File: rtl/mem_port_arbiter.sv
//======================================================================
// Module : mem_port_arbiter
// Shares one memory port between fetch and load/store, sequencing each
// access as a bus transaction. Optional watchdog: MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0
//======================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              flush,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_is_mem;
    logic                r_drop;
    logic                r_we;
    logic [3:0]          r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                w_busy;
    logic                w_grant_mem;
    logic                w_grant_if;
    logic                w_done;
    logic                w_timeout;
    logic                w_if_valid;
    logic                w_mem_valid;

    assign w_busy      = (r_state == BUS_IF) || (r_state == BUS_MEM);
    assign w_grant_mem = (r_state == IDLE) && mem_req;
    assign w_grant_if  = (r_state == IDLE) && !mem_req && if_req && !flush;
    assign w_done      = w_busy && (bus_ready || w_timeout);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_wait;
    logic             r_bus_err;

    // r_wait counts wait cycles already elapsed; the cycle that would make
    // it TIMEOUT_CYC is the one that gives up.
    assign w_timeout = !bus_ready && (r_wait == C_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_busy && w_timeout;
            if (w_grant_mem || w_grant_if) begin
                r_wait <= '0;
            end else if (w_busy && !bus_ready && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_next = BUS_MEM;
                end else if (if_req && !flush) begin
                    w_next = BUS_IF;
                end
            end
            BUS_IF, BUS_MEM: begin
                if (w_done) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_mem    <= 1'b0;
            r_drop      <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_mem) begin
                r_is_mem <= 1'b1;
                r_addr   <= mem_addr;
                r_we     <= mem_we;
                r_be     <= mem_we ? mem_be : 4'hF;
                r_wdata  <= mem_wdata;
            end else if (w_grant_if) begin
                r_is_mem <= 1'b0;
                r_addr   <= if_addr;
                r_we     <= 1'b0;
                r_be     <= 4'hF;
            end
            if (w_done) begin
                if (r_is_mem) begin
                    if (w_timeout) begin
                        r_mem_rdata <= '0;
                    end else if (!r_we) begin
                        r_mem_rdata <= bus_rdata;
                    end
                end else begin
                    r_if_rdata <= w_timeout ? '0 : bus_rdata;
                end
            end
            // A squashed fetch still finishes on the bus; only delivery is dropped.
            if (r_state == RESP) begin
                r_drop <= 1'b0;
            end else if (flush && (r_state == BUS_IF)) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign w_mem_valid = (r_state == RESP) && r_is_mem;
    assign w_if_valid  = (r_state == RESP) && !r_is_mem && !r_drop && !flush;

    assign if_valid  = w_if_valid;
    assign mem_valid = w_mem_valid;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;

    assign bus_req   = w_busy;
    assign bus_we    = (r_state == BUS_MEM) && r_we;
    assign bus_be    = w_busy ? r_be    : 4'h0;
    assign bus_addr  = w_busy ? r_addr  : '0;
    assign bus_wdata = w_busy ? r_wdata : '0;

    assign stall_mem = mem_req && !w_mem_valid;
    assign stall_if  = stall_mem || (if_req && !w_if_valid);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//======================================================================
// Module : tb_mem_port_arbiter
// Directed and randomized checks of mem_port_arbiter against an ordered
// transaction/memory reference model and a bus responder.
// Rev    : 1.0
//======================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush, mem_req, mem_we, bus_ready;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_valid, mem_valid, bus_req, bus_we, stall_if, stall_mem, bus_err;
    logic [3:0]  bus_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    txn_t        exp_bus[$];
    txn_t        e_txn;
    txn_t        cap;
    logic [31:0] bmem [0:255];
    logic [31:0] mdl  [0:255];
    int          resp_wait;
    logic        active;
    int          cnt;
    int          cyc, if_done_cyc, mem_done_cyc, t0, n_err, exp_err, nb, kind;
    logic        if_pending, mem_pending;
    logic [31:0] if_exp, mem_exp, last_mrd, ra, rb, rw, rv;
    logic [3:0]  rbe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bus side: random-latency memory that answers after resp_wait wait cycles.
    initial begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        active    = 1'b0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active    = 1'b0;
                bus_ready = 1'b0;
            end else if (bus_ready) begin
                bus_ready = 1'b0;
            end else if (bus_req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    cap    = '{bus_we, bus_be, bus_addr, bus_wdata};
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected_txn", 64'd1, 64'd0);
                    end else begin
                        e_txn = exp_bus.pop_front();
                        chk("bus_addr", {32'd0, bus_addr}, {32'd0, e_txn.addr});
                        chk("bus_we", {63'd0, bus_we}, {63'd0, e_txn.we});
                        chk("bus_be", {60'd0, bus_be}, {60'd0, e_txn.be});
                        if (e_txn.we) chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, e_txn.wdata});
                    end
                end else begin
                    chk("bus_stable", {63'd0, (bus_we === cap.we) && (bus_be === cap.be) &&
                        (bus_addr === cap.addr) && (bus_wdata === cap.wdata)}, 64'd1);
                end
                if (cnt >= resp_wait) begin
                    bus_ready = 1'b1;
                    bus_rdata = bmem[bus_addr[9:2]];
                    if (bus_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus_be[b]) bmem[bus_addr[9:2]][8*b +: 8] = bus_wdata[8*b +: 8];
                    end
                    active = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        chk("stall_mem", {63'd0, stall_mem}, {63'd0, mem_req & ~mem_valid});
        chk("stall_if", {63'd0, stall_if}, {63'd0, (mem_req & ~mem_valid) | (if_req & ~if_valid)});
        if (bus_err) n_err++;
        if (if_valid) begin
            chk("if_valid_expected", {63'd0, if_pending}, 64'd1);
            chk("if_rdata", {32'd0, if_rdata}, {32'd0, if_exp});
            if_pending  = 1'b0;
            if_req      = 1'b0;
            if_done_cyc = cyc;
        end
        if (mem_valid) begin
            chk("mem_valid_expected", {63'd0, mem_pending}, 64'd1);
            chk("mem_rdata", {32'd0, mem_rdata}, {32'd0, mem_exp});
            mem_pending  = 1'b0;
            mem_req      = 1'b0;
            mem_done_cyc = cyc;
        end
    endtask

    task automatic issue_fetch(input logic [31:0] a);
        if_req     = 1'b1;
        if_addr    = a;
        if_pending = 1'b1;
        if_exp     = mdl[a[9:2]];
        exp_bus.push_back('{1'b0, 4'hF, a, 32'd0});
    endtask

    task automatic issue_mem(input logic we, input logic [3:0] be, input logic [31:0] a,
                             input logic [31:0] wd);
        mem_req     = 1'b1;
        mem_we      = we;
        mem_be      = be;
        mem_addr    = a;
        mem_wdata   = wd;
        mem_pending = 1'b1;
        exp_bus.push_back('{we, we ? be : 4'hF, a, wd});
        if (we) begin
            mem_exp = last_mrd;
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            mem_exp  = mdl[a[9:2]];
            last_mrd = mem_exp;
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((if_pending || mem_pending) && k < budget) begin
            step();
            k++;
        end
        chk("done_within_budget", {63'd0, if_pending | mem_pending}, 64'd0);
        if (if_pending || mem_pending) begin
            if_req = 1'b0; mem_req = 1'b0; if_pending = 1'b0; mem_pending = 1'b0;
        end
    endtask

    task automatic wait_bus(input int budget);
        int k = 0;
        while (!bus_req && k < budget) begin
            step();
            k++;
        end
        chk("bus_req_within_budget", {63'd0, bus_req}, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_req"},   {63'd0, bus_req},   64'd0);
        chk({tag, "_bus_we"},    {63'd0, bus_we},    64'd0);
        chk({tag, "_bus_be"},    {60'd0, bus_be},    64'd0);
        chk({tag, "_bus_addr"},  {32'd0, bus_addr},  64'd0);
        chk({tag, "_bus_wdata"}, {32'd0, bus_wdata}, 64'd0);
        chk({tag, "_if_valid"},  {63'd0, if_valid},  64'd0);
        chk({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd0);
        chk({tag, "_if_rdata"},  {32'd0, if_rdata},  64'd0);
        chk({tag, "_mem_rdata"}, {32'd0, mem_rdata}, 64'd0);
        chk({tag, "_bus_err"},   {63'd0, bus_err},   64'd0);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
        resp_wait = 0; cyc = 0; n_err = 0; exp_err = 0; last_mrd = '0;
        if_pending = 1'b0; mem_pending = 1'b0; if_done_cyc = 0; mem_done_cyc = 0;
        for (int i = 0; i < 256; i++) begin
            rv      = $urandom();
            bmem[i] = {rv[31:8], 8'(i)};
            mdl[i]  = bmem[i];
        end
        bmem[4]    = 32'h0000_0013; mdl[4]    = 32'h0000_0013;
        bmem[8'h80] = 32'hCAFE_F00D; mdl[8'h80] = 32'hCAFE_F00D;

        // Reset state
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Single fetch, two wait cycles
        resp_wait = 2;
        issue_fetch(32'h10);
        t0 = cyc;
        wait_done(20);
        chk("fetch_latency", 64'(if_done_cyc - t0), 64'd4);

        // Simultaneous store and fetch: store goes first
        step();
        resp_wait = 1;
        issue_mem(1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF);
        issue_fetch(32'h30);
        t0 = cyc;
        wait_done(30);
        chk("prio_mem_first", {63'd0, mem_done_cyc < if_done_cyc}, 64'd1);
        chk("prio_mem_latency", 64'(mem_done_cyc - t0), 64'd3);

        // Flushed fetch: 0x20 is squashed, 0x40 delivered
        step();
        resp_wait = 2;
        issue_fetch(32'h20);
        wait_bus(10);
        flush   = 1'b1;
        if_addr = 32'h40;
        if_exp  = mdl[8'h10];
        exp_bus.push_back('{1'b0, 4'hF, 32'h40, 32'd0});
        step();
        flush = 1'b0;
        wait_done(30);

        // Load raised while a fetch is on the bus
        step();
        resp_wait = 1;
        issue_fetch(32'h50);
        wait_bus(10);
        issue_mem(1'b0, 4'hF, 32'h200, 32'd0);
        wait_done(30);
        chk("load_after_fetch", {63'd0, if_done_cyc < mem_done_cyc}, 64'd1);
        chk("load_data_reg", {32'd0, mem_rdata}, 64'h0000_0000_CAFE_F00D);

        // Reset in the middle of a load
        step();
        resp_wait = 3;
        issue_mem(1'b0, 4'hF, 32'h60, 32'd0);
        wait_bus(10);
        step();
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        mem_req = 1'b0; mem_pending = 1'b0; last_mrd = '0;
        step(); step();
        rst = 1'b0;
        step();
        resp_wait = 0;
        issue_fetch(32'h70);
        t0 = cyc;
        wait_done(20);
        chk("post_reset_latency", 64'(if_done_cyc - t0), 64'd2);

        // Randomized traffic in a small address window so stores hit later reads
        for (int it = 0; it < 60; it++) begin
            step();
            resp_wait = $urandom_range(0, 3);
            ra   = {22'd0, 4'h4, 4'($urandom_range(0, 15)), 2'b00};
            rb   = {22'd0, 4'h4, 4'($urandom_range(0, 15)), 2'b00};
            rw   = $urandom();
            rbe  = 4'($urandom_range(1, 15));
            kind = $urandom_range(0, 3);
            t0   = cyc;
            case (kind)
                0: begin
                    issue_fetch(ra);
                    wait_done(30);
                    chk("rnd_fetch_latency", 64'(if_done_cyc - t0), 64'(resp_wait + 2));
                end
                1: begin
                    issue_mem(1'b0, 4'hF, ra, 32'd0);
                    wait_done(30);
                    chk("rnd_load_latency", 64'(mem_done_cyc - t0), 64'(resp_wait + 2));
                end
                2: begin
                    issue_mem(1'b1, rbe, ra, rw);
                    wait_done(30);
                    chk("rnd_store_latency", 64'(mem_done_cyc - t0), 64'(resp_wait + 2));
                end
                default: begin
                    issue_mem(1'($urandom_range(0, 1)), rbe, ra, rw);
                    issue_fetch(rb);
                    wait_done(40);
                    chk("rnd_prio_order", {63'd0, mem_done_cyc < if_done_cyc}, 64'd1);
                end
            endcase
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: bus never answers
        step();
        resp_wait = 1000;
        issue_mem(1'b0, 4'hF, 32'h300, 32'd0);
        mem_exp  = '0;
        last_mrd = '0;
        nb = 0;
        for (int k = 0; k < 40 && mem_pending; k++) begin
            step();
            if (bus_req) nb++;
        end
        chk("timeout_done", {63'd0, mem_pending}, 64'd0);
        chk("timeout_bus_cycles", 64'(nb), 64'd8);
        exp_err = 1;
`endif

        step(); step();
        chk("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        chk("bus_err_count", 64'(n_err), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
